// File: rtl/morse_key_timer.sv
// morse_key_timer
//
// Times presses and releases of a debounced Morse key and turns them into a
// stream of symbols: dot, dash, letter end and word end. Time is measured in
// units of DIV_COUNT clock cycles; the unit grid restarts at every key edge so
// mark and space lengths are measured from the edge itself.
//
// Ports
//   CLK        system clock, rising edge active
//   RST_N      asynchronous active-low reset
//   enable     1 = run timing, 0 = hold timing idle (output buffer still runs)
//   key        debounced key, 1 = pressed
//   sym_valid  output buffer holds an undelivered symbol
//   sym_ready  consumer accepts the buffered symbol
//   sym_code   00 dot, 01 dash, 10 letter end, 11 word end
//   tick       one-cycle pulse at each time-unit boundary
//   overflow   sticky: a symbol was dropped because the buffer was full
//   state      debug view of the FSM: 00 IDLE, 01 MARK, 10 SPACE
//
// Handshake: a symbol transfers in any cycle where sym_valid and sym_ready
// are both 1. While sym_valid=1 and sym_ready=0, sym_valid and sym_code hold
// steady. A new symbol produced in the accept cycle replaces the accepted
// one; a new symbol produced while the buffer is full and not being accepted
// is dropped and sets overflow.

module morse_key_timer #(
    parameter int unsigned DIV_COUNT  = 50,
    parameter int unsigned DOT_MAX    = 2,
    parameter int unsigned LETTER_GAP = 3,
    parameter int unsigned WORD_GAP   = 7
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic       enable,
    input  logic       key,
    output logic       sym_valid,
    input  logic       sym_ready,
    output logic [1:0] sym_code,
    output logic       tick,
    output logic       overflow,
    output logic [1:0] state
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_MARK  = 2'b01,
        ST_SPACE = 2'b10
    } state_t;

    localparam logic [15:0] DIV_LAST  = 16'(DIV_COUNT - 1);
    localparam logic [7:0]  DOT_LIM   = 8'(DOT_MAX);
    localparam logic [7:0]  LETTER_U  = 8'(LETTER_GAP);
    localparam logic [7:0]  WORD_U    = 8'(WORD_GAP);
    localparam logic [7:0]  UNITS_MAX = 8'hFF;

    localparam logic [1:0] SYM_DOT    = 2'b00;
    localparam logic [1:0] SYM_DASH   = 2'b01;
    localparam logic [1:0] SYM_LETTER = 2'b10;
    localparam logic [1:0] SYM_WORD   = 2'b11;

    state_t      cur_state;
    state_t      next_state;
    logic [15:0] pre_count;
    logic [7:0]  units;
    logic [7:0]  units_now;
    logic        key_d;
    logic        rise;
    logic        fall;
    logic        key_edge;
    logic        emit;
    logic [1:0]  emit_code;

    assign rise     = key & ~key_d;
    assign fall     = ~key & key_d;
    assign key_edge = rise | fall;

    assign tick  = enable && (pre_count == DIV_LAST);
    assign state = cur_state;

    // Unit count including a boundary that lands in this very cycle. A mark
    // released on the cycle that completes its Nth unit counts as N units,
    // and a gap is recognised on the tick that brings it to its length.
    assign units_now = (tick && (units != UNITS_MAX)) ? units + 8'd1 : units;

    // Prescaler, unit counter, key history and state register.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            key_d     <= 1'b0;
            pre_count <= 16'd0;
            units     <= 8'd0;
            cur_state <= ST_IDLE;
        end else begin
            key_d <= key;

            if (!enable || key_edge || tick) begin
                pre_count <= 16'd0;
            end else begin
                pre_count <= pre_count + 16'd1;
            end

            if (!enable || key_edge) begin
                units <= 8'd0;
            end else begin
                units <= units_now;
            end

            cur_state <= next_state;
        end
    end

    // Next-state and symbol generation.
    always_comb begin
        next_state = cur_state;
        emit       = 1'b0;
        emit_code  = SYM_DOT;

        if (!enable) begin
            next_state = ST_IDLE;
        end else begin
            case (cur_state)
                ST_IDLE: begin
                    if (rise) begin
                        next_state = ST_MARK;
                    end
                end
                ST_MARK: begin
                    if (fall) begin
                        emit       = 1'b1;
                        emit_code  = (units_now < DOT_LIM) ? SYM_DOT : SYM_DASH;
                        next_state = ST_SPACE;
                    end
                end
                ST_SPACE: begin
                    if (rise) begin
                        next_state = ST_MARK;
                    end else if (tick && (units != WORD_U) && (units_now == WORD_U)) begin
                        emit       = 1'b1;
                        emit_code  = SYM_WORD;
                        next_state = ST_IDLE;
                    end else if (tick && (units != LETTER_U) && (units_now == LETTER_U)) begin
                        // units only grows during a space, so this fires once.
                        emit      = 1'b1;
                        emit_code = SYM_LETTER;
                    end
                end
                default: begin
                    next_state = ST_IDLE;
                end
            endcase
        end
    end

    // One-entry output buffer with sticky overflow.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            sym_valid <= 1'b0;
            sym_code  <= SYM_DOT;
            overflow  <= 1'b0;
        end else begin
            if (emit) begin
                if (!sym_valid || sym_ready) begin
                    sym_valid <= 1'b1;
                    sym_code  <= emit_code;
                end else begin
                    overflow <= 1'b1;
                end
            end else if (sym_valid && sym_ready) begin
                sym_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_morse_key_timer.sv
// Testbench for morse_key_timer (DIV_COUNT=4, DOT_MAX=2, LETTER_GAP=3,
// WORD_GAP=7). A timing model computes mark/space lengths from the cycle
// numbers of key edges and checks every output each cycle; directed
// scenarios add literal expectations and a scoreboard of delivered symbols.

module tb_morse_key_timer;

    localparam int DIV  = 4;
    localparam int DOTM = 2;
    localparam int LG   = 3;
    localparam int WG   = 7;

    // ---------------- clock / reset ----------------
    logic       clk       = 1'b0;
    logic       rst_n     = 1'b0;
    logic       enable    = 1'b0;
    logic       key       = 1'b0;
    logic       sym_ready = 1'b1;
    logic       sym_valid;
    logic [1:0] sym_code;
    logic       tick;
    logic       overflow;
    logic [1:0] state;

    always #5 clk = ~clk;

    morse_key_timer #(
        .DIV_COUNT (DIV),
        .DOT_MAX   (DOTM),
        .LETTER_GAP(LG),
        .WORD_GAP  (WG)
    ) dut (
        .CLK      (clk),
        .RST_N    (rst_n),
        .enable   (enable),
        .key      (key),
        .sym_valid(sym_valid),
        .sym_ready(sym_ready),
        .sym_code (sym_code),
        .tick     (tick),
        .overflow (overflow),
        .state    (state)
    );

    // ---------------- checking helpers ----------------
    int n_checks = 0;
    int n_pass   = 0;
    logic [1:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Mode 0 idle, 1 key down, 2 key up after a mark. Lengths come from
    // the cycle numbers at which the key changed.
    int         cyc     = 0;
    int         m_mode  = 0;
    int         t_rise  = 0;
    int         t_fall  = 0;
    int         m_age   = 1;   // cycles since the unit grid last restarted
    logic       m_pk    = 1'b0;
    logic       m_valid = 1'b0;
    logic [1:0] m_code  = 2'b00;
    logic       m_ovf   = 1'b0;
    logic       m_rise, m_fall, m_emit, m_tick;
    logic [1:0] m_ecode;
    int         m_units;

    always @(negedge clk) begin
        cyc++;
        if (!rst_n) begin
            m_mode  = 0;
            m_age   = 1;
            m_pk    = 1'b0;
            m_valid = 1'b0;
            m_code  = 2'b00;
            m_ovf   = 1'b0;
            check("rst_valid", sym_valid, 0);
            check("rst_state", state, 0);
            check("rst_overflow", overflow, 0);
            check("rst_tick", tick, 0);
        end else begin
            m_tick = enable && ((m_age % DIV) == 0);
            check("tick", tick, m_tick);
            check("state", state, m_mode);
            check("sym_valid", sym_valid, m_valid);
            if (m_valid) check("sym_code", sym_code, m_code);
            check("overflow", overflow, m_ovf);

            // scoreboard of delivered symbols
            if (sym_valid && sym_ready) begin
                check("sb_expected_pending", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) check("sb_code", sym_code, exp_q.pop_front());
            end

            // advance the model to the next cycle
            m_rise  = key && !m_pk;
            m_fall  = !key && m_pk;
            m_emit  = 1'b0;
            m_ecode = 2'b00;
            if (!enable) begin
                m_mode = 0;
            end else if (m_mode == 0) begin
                if (m_rise) begin
                    m_mode = 1;
                    t_rise = cyc;
                end
            end else if (m_mode == 1) begin
                if (m_fall) begin
                    m_units = (cyc - t_rise) / DIV;
                    if (m_units > 255) m_units = 255;
                    m_emit  = 1'b1;
                    m_ecode = (m_units < DOTM) ? 2'b00 : 2'b01;
                    m_mode  = 2;
                    t_fall  = cyc;
                end
            end else begin
                if (m_rise) begin
                    m_mode = 1;
                    t_rise = cyc;
                end else if (cyc - t_fall == LG * DIV) begin
                    m_emit  = 1'b1;
                    m_ecode = 2'b10;
                end else if (cyc - t_fall == WG * DIV) begin
                    m_emit  = 1'b1;
                    m_ecode = 2'b11;
                    m_mode  = 0;
                end
            end

            if (m_emit) begin
                if (!m_valid || sym_ready) begin
                    m_valid = 1'b1;
                    m_code  = m_ecode;
                end else begin
                    m_ovf = 1'b1;
                end
            end else if (m_valid && sym_ready) begin
                m_valid = 1'b0;
            end

            if (!enable || m_rise || m_fall) m_age = 1;
            else m_age++;
            m_pk = key;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic wait_cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic press(input int len);
        key = 1'b1;
        wait_cyc(len);
        key = 1'b0;
    endtask

    task automatic expect_syms(input logic [1:0] a, input logic [1:0] b, input logic [1:0] c);
        exp_q.push_back(a);
        exp_q.push_back(b);
        exp_q.push_back(c);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
        $fatal(1, "watchdog");
    end

    // ---------------- directed scenarios ----------------
    initial begin
        wait_cyc(2);
        check("reset_sym_code", sym_code, 0);
        rst_n  = 1'b1;
        enable = 1'b1;
        wait_cyc(3);

        // Scenario 1: 6-cycle mark -> dot, letter end, word end
        expect_syms(2'b00, 2'b10, 2'b11);
        press(6);                        // fall seen in cycle 6
        wait_cyc(1);
        check("s1_dot_valid", sym_valid, 1);
        check("s1_dot_code", sym_code, 0);
        wait_cyc(1);
        check("s1_dot_pulse", sym_valid, 0);
        check("s1_space_state", state, 2);
        wait_cyc(10);
        check("s1_before_letter", sym_valid, 0);
        wait_cyc(1);
        check("s1_letter_valid", sym_valid, 1);
        check("s1_letter_code", sym_code, 2);
        wait_cyc(16);
        check("s1_word_valid", sym_valid, 1);
        check("s1_word_code", sym_code, 3);
        wait_cyc(1);
        check("s1_idle", state, 0);
        wait_cyc(3);

        // Scenario 2: mark length classification
        exp_q.push_back(2'b01);
        exp_q.push_back(2'b01);
        expect_syms(2'b00, 2'b10, 2'b11);
        press(12);
        wait_cyc(1);
        check("s2_12_code", sym_code, 1);
        wait_cyc(3);
        press(8);
        wait_cyc(1);
        check("s2_8_valid", sym_valid, 1);
        check("s2_8_code", sym_code, 1);
        wait_cyc(3);
        press(7);
        wait_cyc(1);
        check("s2_7_valid", sym_valid, 1);
        check("s2_7_code", sym_code, 0);
        wait_cyc(39);
        expect_syms(2'b00, 2'b10, 2'b11);
        press(1);
        wait_cyc(1);
        check("s2_1_code", sym_code, 0);
        wait_cyc(40);
        expect_syms(2'b01, 2'b10, 2'b11);
        press(1100);
        wait_cyc(1);
        check("s2_sat_code", sym_code, 1);
        wait_cyc(40);

        // Scenario 4: accept in the same cycle as a new fall
        expect_syms(2'b00, 2'b01, 2'b10);
        exp_q.push_back(2'b11);
        sym_ready = 1'b0;
        press(2);
        wait_cyc(4);
        check("s4_held_valid", sym_valid, 1);
        check("s4_held_code", sym_code, 0);
        key = 1'b1;
        wait_cyc(8);
        key       = 1'b0;
        sym_ready = 1'b1;
        wait_cyc(1);
        check("s4_new_valid", sym_valid, 1);
        check("s4_new_code", sym_code, 1);
        check("s4_no_overflow", overflow, 0);
        wait_cyc(40);

        // Scenario 5: enable dropped mid-mark, re-enabled with key held
        expect_syms(2'b00, 2'b10, 2'b11);
        key = 1'b1;
        wait_cyc(6);
        enable = 1'b0;
        wait_cyc(1);
        check("s5_forced_idle", state, 0);
        for (int i = 0; i < 8; i++) begin
            check("s5_tick_low", tick, 0);
            wait_cyc(1);
        end
        enable = 1'b1;
        wait_cyc(8);
        check("s5_still_idle", state, 0);
        check("s5_no_symbol", sym_valid, 0);
        key = 1'b0;
        wait_cyc(3);
        check("s5_release_idle", state, 0);
        key = 1'b1;
        wait_cyc(1);
        check("s5_new_mark", state, 1);
        wait_cyc(4);
        key = 1'b0;
        wait_cyc(40);

        // Scenario 3: buffer full -> drop and sticky overflow
        expect_syms(2'b00, 2'b10, 2'b11);
        sym_ready = 1'b0;
        press(2);
        wait_cyc(4);
        press(8);
        wait_cyc(1);
        check("s3_kept_valid", sym_valid, 1);
        check("s3_kept_code", sym_code, 0);
        check("s3_overflow", overflow, 1);
        wait_cyc(2);
        sym_ready = 1'b1;
        wait_cyc(1);
        check("s3_dash_dropped", sym_valid, 0);
        check("s3_overflow_sticky", overflow, 1);
        wait_cyc(40);

        // Scenario 6: reset mid-space with a pending symbol, key held
        sym_ready = 1'b0;
        press(2);
        wait_cyc(3);
        check("s6_pending", sym_valid, 1);
        rst_n = 1'b0;
        key   = 1'b1;
        #1;
        check("s6_async_valid", sym_valid, 0);
        check("s6_async_code", sym_code, 0);
        check("s6_async_overflow", overflow, 0);
        check("s6_async_state", state, 0);
        check("s6_async_tick", tick, 0);
        wait_cyc(1);
        rst_n     = 1'b1;
        sym_ready = 1'b1;
        expect_syms(2'b00, 2'b10, 2'b11);
        wait_cyc(1);
        check("s6_mark_after_reset", state, 1);
        wait_cyc(3);
        key = 1'b0;
        wait_cyc(40);

        check("sb_all_delivered", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/morse_key_timer.md
MORSE_KEY_TIMER -- requirements
Module: morse_key_timer

Interface
REQ-001 Parameter DIV_COUNT, default 50, is the number of CLK cycles per time unit; the legal range is 2..65535.
REQ-002 Parameter DOT_MAX, default 2: a mark shorter than DOT_MAX units is a dot; the legal range is 1..254.
REQ-003 Parameter LETTER_GAP, default 3, is the space length in units that ends a letter.
REQ-004 Parameter WORD_GAP, default 7, is the space length in units that ends a word; the block requires 1 <= LETTER_GAP < WORD_GAP <= 255.
REQ-005 CLK  input  1  is the single system clock; all state changes on the rising edge.
REQ-006 RST_N  input  1  is the asynchronous, active-low reset.
REQ-007 enable  input  1  is high to run timing; low to hold the block idle.
REQ-008 key  input  1  is the Morse key, already synchronized and debounced; 1 means pressed.
REQ-009 sym_valid  output  1  is high when sym_code holds an undelivered symbol.
REQ-010 sym_ready  input  1  is the consumer accept signal.
REQ-011 sym_code  output  2  carries the symbol: 00 dot, 01 dash, 10 letter end, 11 word end.
REQ-012 tick  output  1  is a one-cycle pulse at each time-unit boundary.
REQ-013 overflow  output  1  is a sticky flag: a symbol was dropped.
REQ-014 state  output  2  is the FSM state for debug LEDs: 00 IDLE, 01 MARK, 10 SPACE.

Function
REQ-015 Prescaler: a 16-bit count runs 0..DIV_COUNT-1 while enable=1; tick=1 in the cycle where count==DIV_COUNT-1, and the count then wraps to 0.
REQ-016 key is registered into key_d every cycle; rise = key & ~key_d and fall = ~key & key_d.
REQ-017 On rise or fall, the prescaler reloads 0 and the unit counter clears to 0 on the next edge, so unit boundaries align to key edges.
REQ-018 Unit counter: 8 bits, increments on tick, and saturates at 255 with no wrap.
REQ-019 IDLE: on rise -> MARK; otherwise the block stays in IDLE and emits nothing.
REQ-020 MARK: on fall, the block emits dot if units < DOT_MAX, else dash, and moves to SPACE.
REQ-021 SPACE: on rise -> MARK.
REQ-022 SPACE: on the tick where units becomes LETTER_GAP, the block emits letter end, exactly once per space.
REQ-023 SPACE: on the tick where units becomes WORD_GAP, the block emits word end and moves to IDLE.
REQ-024 A mark shorter than one tick (units=0) is a dot; a saturated mark (255) is a dash.
REQ-025 Emission latency: the symbol is registered, so sym_valid and sym_code are valid one cycle after the cycle in which fall or the gap tick is seen.
REQ-026 Output buffer: one entry; sym_valid stays high, and sym_code stays stable, until the cycle with sym_valid & sym_ready.
REQ-027 If a new symbol arrives in the same cycle as an accept, the new symbol loads and sym_valid stays 1.
REQ-028 If a new symbol arrives while sym_valid=1 and sym_ready=0, the new symbol is dropped, the buffered symbol is kept, and overflow is set to 1.
REQ-029 Once set, overflow clears only on reset.
REQ-030 While enable=0: the prescaler and unit counter hold 0, tick=0, the FSM is forced to IDLE, and no symbols are emitted.
REQ-031 While enable=0, the output buffer and handshake continue to operate.
REQ-032 When enable rises with key=1, no rise is detected, so the block stays in IDLE until key releases and presses again.

Reset
REQ-033 RST_N=0 asynchronously forces: FSM=IDLE, prescaler=0, units=0, key_d=0, sym_valid=0, sym_code=00, tick=0, overflow=0.
REQ-034 Reset asserted mid-mark or mid-space discards partial timing; a pending output symbol is lost.
REQ-035 After release, the first active edge sees key_d=0, so a key held through reset produces a rise and enters MARK.

Verification (DIV_COUNT=4, DOT_MAX=2, LETTER_GAP=3, WORD_GAP=7, sym_ready=1 unless stated)
REQ-036 Scenario 1: key high 6 cycles then low -> dot (00) with sym_valid pulsing 1 cycle after the fall; then letter end (10) after 12 cycles of space; then word end (11) at 28 cycles; state ends at 00.
REQ-037 Scenario 2: key high 12 cycles -> dash (01); key high exactly 8 cycles (2 units) -> dash; key high 7 cycles -> dot.
REQ-038 Scenario 3: sym_ready=0; send a dot, then a dash -> sym_code stays 00 with sym_valid=1 and overflow=1; raise sym_ready -> 00 is accepted and the dash is not presented.
REQ-039 Scenario 4: sym_ready asserted in the same cycle a new fall is seen -> the old symbol is accepted, the new symbol is presented next cycle, and overflow stays 0.
REQ-040 Scenario 5: enable=0 mid-mark -> state=00, tick stays 0, no symbol; set enable=1 with key still high -> no MARK until key is released and pressed again.
REQ-041 Scenario 6: RST_N low for 1 cycle mid-space with a pending symbol -> all outputs reset values immediately (asynchronously); a key held through reset release gives state=01 two cycles later.
